// File: rtl/rx_frontend_cfg_seq.sv
// rx_frontend_cfg_seq
//   Buffers a batch of settings-bus writes from a control source and replays
//   them onto the frontend settings bus when committed. Replay starts right
//   away or on the next sync_in pulse, so a reconfiguration lands atomically
//   relative to the sample stream. Consecutive strobes are separated by
//   GAP_CYCLES idle cycles.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   s_wr_stb/addr/data buffer-write request from the control source
//   s_wr_ready        write would be accepted (IDLE and buffer not full)
//   commit            pulse: start replaying the buffer
//   commit_on_sync    level sampled with commit: wait for sync_in first
//   sync_in           sample-timing sync pulse
//   abort             pulse: cancel replay and flush the buffer
//   set_stb/addr/data settings bus towards the frontend
//   busy              replay armed or in progress
//   done              one-cycle pulse when a batch has been fully issued
//   overflow          one-cycle pulse when a write was dropped
//   fill              current buffer occupancy
module rx_frontend_cfg_seq #(
  parameter int DEPTH_LOG2 = 3,
  parameter int SR_AW      = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_wr_stb,
  input  logic [SR_AW-1:0]      s_wr_addr,
  input  logic [31:0]           s_wr_data,
  output logic                  s_wr_ready,
  input  logic                  commit,
  input  logic                  commit_on_sync,
  input  logic                  sync_in,
  input  logic                  abort,
  output logic                  set_stb,
  output logic [SR_AW-1:0]      set_addr,
  output logic [31:0]           set_data,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [DEPTH_LOG2:0]   fill
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int GW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ARMED, ISSUE, GAP} state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [SR_AW-1:0]      r_memAddr [DEPTH];
  logic [31:0]           r_memData [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wrPtr;
  logic [DEPTH_LOG2-1:0] r_rdPtr;
  logic [DEPTH_LOG2:0]   r_fill;
  logic [DEPTH_LOG2:0]   w_fillNext;
  logic [GW-1:0]         r_gapCnt;
  logic                  r_setStb;
  logic [SR_AW-1:0]      r_setAddr;
  logic [31:0]           r_setData;
  logic                  r_done;
  logic                  r_overflow;
  logic                  w_wrAccept;
  logic                  w_issue;
  logic                  w_doneNext;
  logic                  w_gapLoad;
  logic [SR_AW-1:0]      w_headAddr;
  logic [31:0]           w_headData;

  assign s_wr_ready = (r_state == IDLE) && (r_fill < FULL_LEVEL);
  assign w_wrAccept = s_wr_stb && s_wr_ready && !abort;
  assign w_fillNext = r_fill + {{DEPTH_LOG2{1'b0}}, w_wrAccept};

  // A write landing in the same cycle as a commit on an empty buffer has not
  // reached the memory yet, so the head entry is taken straight off the
  // write port in that case.
  assign w_headAddr = (r_fill == '0) ? s_wr_addr : r_memAddr[r_rdPtr];
  assign w_headData = (r_fill == '0) ? s_wr_data : r_memData[r_rdPtr];

  assign set_stb  = r_setStb;
  assign set_addr = r_setAddr;
  assign set_data = r_setData;
  assign done     = r_done;
  assign overflow = r_overflow;
  assign fill     = r_fill;
  assign busy     = (r_state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. w_issue marks the edge that loads a strobe and pops the
  // head, so the strobe is visible in the first cycle spent in ISSUE. During
  // ISSUE r_fill already excludes the entry being strobed.
  always_comb begin
    w_nextState = r_state;
    w_issue     = 1'b0;
    w_doneNext  = 1'b0;
    w_gapLoad   = 1'b0;
    if (abort) begin
      w_nextState = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (commit) begin
            if (w_fillNext == '0) begin
              w_doneNext = 1'b1;
            end else if (commit_on_sync) begin
              w_nextState = ARMED;
            end else begin
              w_nextState = ISSUE;
              w_issue     = 1'b1;
            end
          end
        end
        ARMED: begin
          if (sync_in) begin
            w_nextState = ISSUE;
            w_issue     = 1'b1;
          end
        end
        ISSUE: begin
          if (r_fill != '0) begin
            if (GAP_CYCLES > 0) begin
              w_nextState = GAP;
              w_gapLoad   = 1'b1;
            end else begin
              w_nextState = ISSUE;
              w_issue     = 1'b1;
            end
          end else begin
            w_nextState = IDLE;
            w_doneNext  = 1'b1;
          end
        end
        GAP: begin
          if (r_gapCnt == '0) begin
            w_nextState = ISSUE;
            w_issue     = 1'b1;
          end
        end
        default: w_nextState = IDLE;
      endcase
    end
  end

  // Buffer storage has no reset; occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    if (w_wrAccept) begin
      r_memAddr[r_wrPtr] <= s_wr_addr;
      r_memData[r_wrPtr] <= s_wr_data;
    end
  end

  // Pointers, occupancy, gap counter and the registered bus outputs. Abort
  // flushes the buffer but leaves the last issued address/data on the bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_fill     <= '0;
      r_gapCnt   <= '0;
      r_setStb   <= 1'b0;
      r_setAddr  <= '0;
      r_setData  <= '0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_setStb   <= w_issue;
      r_done     <= w_doneNext;
      r_overflow <= s_wr_stb && !w_wrAccept && !abort;
      if (abort) begin
        r_wrPtr <= '0;
        r_rdPtr <= '0;
        r_fill  <= '0;
      end else begin
        if (w_wrAccept) begin
          r_wrPtr <= r_wrPtr + 1'b1;
        end
        if (w_issue) begin
          r_rdPtr   <= r_rdPtr + 1'b1;
          r_setAddr <= w_headAddr;
          r_setData <= w_headData;
        end
        case ({w_wrAccept, w_issue})
          2'b10:   r_fill <= r_fill + 1'b1;
          2'b01:   r_fill <= r_fill - 1'b1;
          default: r_fill <= r_fill;
        endcase
      end
      if (w_gapLoad) begin
        r_gapCnt <= GAP_LOAD;
      end else if (r_state == GAP && r_gapCnt != '0) begin
        r_gapCnt <= r_gapCnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rx_frontend_cfg_seq.sv
// tb_rx_frontend_cfg_seq
//   Directed bench for rx_frontend_cfg_seq with a transaction-level model:
//   pending writes sit in a queue, and a commit turns the whole queue into a
//   schedule of strobe cycles keyed by cycle number. Outputs are compared with
//   that schedule every cycle, and each scenario is also pinned to literal
//   cycle numbers and values.
module tb_rx_frontend_cfg_seq;

  localparam int DL2 = 3;
  localparam int AW  = 8;
  localparam int G   = 1;
  localparam int DEPTH = 1 << DL2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            s_wr_stb = 1'b0;
  logic [AW-1:0]   s_wr_addr = '0;
  logic [31:0]     s_wr_data = '0;
  logic            s_wr_ready;
  logic            commit = 1'b0;
  logic            commit_on_sync = 1'b0;
  logic            sync_in = 1'b0;
  logic            abort = 1'b0;
  logic            set_stb;
  logic [AW-1:0]   set_addr;
  logic [31:0]     set_data;
  logic            busy;
  logic            done;
  logic            overflow;
  logic [DL2:0]    fill;

  rx_frontend_cfg_seq #(.DEPTH_LOG2(DL2), .SR_AW(AW), .GAP_CYCLES(G)) dut (
    .clk(clk), .reset(reset),
    .s_wr_stb(s_wr_stb), .s_wr_addr(s_wr_addr), .s_wr_data(s_wr_data),
    .s_wr_ready(s_wr_ready),
    .commit(commit), .commit_on_sync(commit_on_sync), .sync_in(sync_in),
    .abort(abort),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .busy(busy), .done(done), .overflow(overflow), .fill(fill)
  );

  always #5 clk = ~clk;

  int nVec = 0;
  int nFail = 0;
  int cyc = 0;

  // Model state: cycle N runs from posedge N to posedge N+1.
  logic [AW+31:0] mq[$];
  logic [AW+31:0] schedStb[int];
  bit             schedDone[int];
  bit             schedOvf[int];
  bit             armed = 0;
  int             busyFrom = 0;
  int             lastStrobe = -1;
  logic [AW-1:0]  holdAddr = '0;
  logic [31:0]    holdData = '0;

  // Observation logs for the literal checks.
  int             stbCyc[$];
  logic [AW-1:0]  stbAddr[$];
  logic [31:0]    stbData[$];
  int             doneCyc[$];
  int             ovfCnt = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int modelFill(input int c);
    int n;
    n = mq.size();
    foreach (schedStb[k]) if (k > c) n++;
    return n;
  endfunction

  function automatic bit modelIdle(input int c);
    return !armed && (c > lastStrobe);
  endfunction

  // Turn every pending entry into a strobe, one every G+1 cycles.
  task automatic scheduleBatch(input int start);
    int k;
    k = 0;
    busyFrom = start;
    while (mq.size() > 0) begin
      schedStb[start + k * (G + 1)] = mq.pop_front();
      k++;
    end
    lastStrobe = start + (k - 1) * (G + 1);
    schedDone[lastStrobe + 1] = 1;
  endtask

  // Model update from the inputs of the cycle that is ending.
  always @(posedge clk) begin : modelProc
    int  n;
    int  f;
    bit  idle;
    bit  wasArmed;
    bit  acc;
    int  drop[$];
    n = cyc;
    if (reset) begin
      mq.delete(); schedStb.delete(); schedDone.delete(); schedOvf.delete();
      armed = 0; lastStrobe = -1; busyFrom = 0;
      holdAddr = '0; holdData = '0;
    end else if (abort) begin
      mq.delete();
      armed = 0;
      drop.delete();
      foreach (schedStb[k]) if (k > n) drop.push_back(k);
      foreach (drop[i]) schedStb.delete(drop[i]);
      drop.delete();
      foreach (schedDone[k]) if (k > n) drop.push_back(k);
      foreach (drop[i]) schedDone.delete(drop[i]);
      if (lastStrobe > n) lastStrobe = n;
    end else begin
      idle = modelIdle(n);
      f = modelFill(n);
      wasArmed = armed;
      acc = s_wr_stb && idle && (f < DEPTH);
      if (s_wr_stb && !acc) schedOvf[n + 1] = 1;
      if (acc) mq.push_back({s_wr_addr, s_wr_data});
      if (idle && commit) begin
        if (mq.size() == 0) schedDone[n + 1] = 1;
        else if (commit_on_sync) armed = 1;
        else scheduleBatch(n + 1);
      end else if (wasArmed && sync_in) begin
        armed = 0;
        scheduleBatch(n + 1);
      end
    end
    cyc = n + 1;
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin : compareProc
    int  c;
    bit  expStb;
    bit  expBusy;
    int  expFill;
    if (cyc > 0) begin
      c = cyc;
      expStb = schedStb.exists(c);
      if (expStb) {holdAddr, holdData} = schedStb[c];
      expFill = modelFill(c);
      expBusy = armed || (c >= busyFrom && c <= lastStrobe);
      checkOutput("set_stb", 32'(set_stb), 32'(expStb));
      checkOutput("set_addr", 32'(set_addr), 32'(holdAddr));
      checkOutput("set_data", set_data, holdData);
      checkOutput("done", 32'(done), 32'(schedDone.exists(c)));
      checkOutput("overflow", 32'(overflow), 32'(schedOvf.exists(c)));
      checkOutput("busy", 32'(busy), 32'(expBusy));
      checkOutput("fill", 32'(fill), 32'(expFill));
      checkOutput("s_wr_ready", 32'(s_wr_ready), 32'(modelIdle(c) && expFill < DEPTH));
      if (!reset) begin
        if (set_stb === 1'b1) begin
          stbCyc.push_back(c); stbAddr.push_back(set_addr); stbData.push_back(set_data);
        end
        if (done === 1'b1) doneCyc.push_back(c);
        if (overflow === 1'b1) ovfCnt++;
      end
    end
  end

  function automatic int cycAt(input int i);
    return (i < stbCyc.size()) ? stbCyc[i] : -1;
  endfunction

  function automatic logic [31:0] addrAt(input int i);
    return (i < stbAddr.size()) ? 32'(stbAddr[i]) : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] dataAt(input int i);
    return (i < stbData.size()) ? stbData[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic int doneAt(input int i);
    return (i < doneCyc.size()) ? doneCyc[i] : -1;
  endfunction

  task automatic clearLogs();
    stbCyc.delete(); stbAddr.delete(); stbData.delete(); doneCyc.delete();
    ovfCnt = 0;
  endtask

  // Drive one cycle of inputs, then move to just after the next rising edge.
  task automatic applyStimulus(input bit stb, input logic [AW-1:0] a, input logic [31:0] d,
                               input bit cm, input bit cos, input bit sy, input bit ab);
    s_wr_stb = stb; s_wr_addr = a; s_wr_data = d;
    commit = cm; commit_on_sync = cos; sync_in = sy; abort = ab;
    @(posedge clk);
    #2;
    s_wr_stb = 0; commit = 0; sync_in = 0; abort = 0; commit_on_sync = 0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, '0, '0, 0, 0, 0, 0);
  endtask

  initial begin : stimulus
    int n;
    int s;
    repeat (3) @(posedge clk);
    #2;
    reset = 0;
    idleCycles(2);

    // Three writes, immediate commit, one idle cycle between strobes.
    clearLogs();
    applyStimulus(1, 8'd4, 32'h10, 0, 0, 0, 0);
    applyStimulus(1, 8'd0, 32'h0, 0, 0, 0, 0);
    applyStimulus(1, 8'd1, 32'h0, 0, 0, 0, 0);
    n = cyc;
    applyStimulus(0, '0, '0, 1, 0, 0, 0);
    idleCycles(8);
    checkOutput("t1_nstb", 32'(stbCyc.size()), 32'd3);
    checkOutput("t1_cyc0", 32'(cycAt(0)), 32'(n + 1));
    checkOutput("t1_cyc1", 32'(cycAt(1)), 32'(n + 3));
    checkOutput("t1_cyc2", 32'(cycAt(2)), 32'(n + 5));
    checkOutput("t1_addr0", addrAt(0), 32'd4);
    checkOutput("t1_addr1", addrAt(1), 32'd0);
    checkOutput("t1_addr2", addrAt(2), 32'd1);
    checkOutput("t1_data0", dataAt(0), 32'h10);
    checkOutput("t1_done", 32'(doneAt(0)), 32'(n + 6));
    checkOutput("t1_fill", 32'(fill), 32'd0);

    // Commit armed on sync, sync arrives 20 cycles later.
    clearLogs();
    applyStimulus(1, 8'd2, 32'hC000_0000, 0, 0, 0, 0);
    n = cyc;
    applyStimulus(0, '0, '0, 1, 1, 0, 0);
    idleCycles(19);
    s = cyc;
    checkOutput("t2_busy_armed", 32'(busy), 32'd1);
    applyStimulus(0, '0, '0, 0, 0, 1, 0);
    idleCycles(4);
    checkOutput("t2_nstb", 32'(stbCyc.size()), 32'd1);
    checkOutput("t2_sync_at", 32'(s), 32'(n + 20));
    checkOutput("t2_cyc", 32'(cycAt(0)), 32'(s + 1));
    checkOutput("t2_data", dataAt(0), 32'hC000_0000);
    checkOutput("t2_done", 32'(doneAt(0)), 32'(s + 2));

    // Nine writes into an eight-entry buffer, then replay.
    clearLogs();
    for (int i = 0; i < 9; i++) applyStimulus(1, 8'(8'h20 + i), 32'h1000 + 32'(i), 0, 0, 0, 0);
    checkOutput("t3_fill", 32'(fill), 32'd8);
    checkOutput("t3_ready", 32'(s_wr_ready), 32'd0);
    idleCycles(1);
    checkOutput("t3_ovf", 32'(ovfCnt), 32'd1);
    clearLogs();
    applyStimulus(0, '0, '0, 1, 0, 0, 0);
    idleCycles(20);
    checkOutput("t3_nstb", 32'(stbCyc.size()), 32'd8);
    for (int i = 0; i < 8; i++) checkOutput("t3_addr", addrAt(i), 32'h20 + 32'(i));
    checkOutput("t3_data7", dataAt(7), 32'h1007);

    // Six entries, abort on the cycle of the third strobe.
    clearLogs();
    for (int i = 0; i < 6; i++) applyStimulus(1, 8'(8'h40 + i), 32'(i * 3), 0, 0, 0, 0);
    n = cyc;
    applyStimulus(0, '0, '0, 1, 0, 0, 0);
    idleCycles(4);
    checkOutput("t4_stb_at_abort", 32'(set_stb), 32'd1);
    applyStimulus(0, '0, '0, 0, 0, 0, 1);
    checkOutput("t4_fill_after", 32'(fill), 32'd0);
    checkOutput("t4_ready_after", 32'(s_wr_ready), 32'd1);
    checkOutput("t4_busy_after", 32'(busy), 32'd0);
    applyStimulus(1, 8'h55, 32'hABCD, 0, 0, 0, 0);
    checkOutput("t4_fill_new", 32'(fill), 32'd1);
    idleCycles(6);
    checkOutput("t4_nstb", 32'(stbCyc.size()), 32'd3);
    checkOutput("t4_cyc2", 32'(cycAt(2)), 32'(n + 5));
    checkOutput("t4_ndone", 32'(doneCyc.size()), 32'd0);
    applyStimulus(0, '0, '0, 1, 0, 0, 0);
    idleCycles(4);

    // Write and commit together on an empty buffer.
    clearLogs();
    n = cyc;
    applyStimulus(1, 8'h77, 32'h1234_5678, 1, 0, 0, 0);
    idleCycles(4);
    checkOutput("t5_nstb", 32'(stbCyc.size()), 32'd1);
    checkOutput("t5_cyc", 32'(cycAt(0)), 32'(n + 1));
    checkOutput("t5_addr", addrAt(0), 32'h77);
    checkOutput("t5_data", dataAt(0), 32'h1234_5678);
    checkOutput("t5_done", 32'(doneAt(0)), 32'(n + 2));

    // Commit on an empty buffer.
    clearLogs();
    n = cyc;
    applyStimulus(0, '0, '0, 1, 0, 0, 0);
    idleCycles(3);
    checkOutput("t6_nstb", 32'(stbCyc.size()), 32'd0);
    checkOutput("t6_done", 32'(doneAt(0)), 32'(n + 1));
    checkOutput("t6_ndone", 32'(doneCyc.size()), 32'd1);

    // Write and commit while a replay is running are dropped/ignored.
    clearLogs();
    applyStimulus(1, 8'h61, 32'h61, 0, 0, 0, 0);
    applyStimulus(1, 8'h62, 32'h62, 0, 0, 0, 0);
    applyStimulus(0, '0, '0, 1, 0, 0, 0);
    applyStimulus(1, 8'h63, 32'h63, 1, 0, 0, 0);
    idleCycles(6);
    checkOutput("t7_nstb", 32'(stbCyc.size()), 32'd2);
    checkOutput("t7_ovf", 32'(ovfCnt), 32'd1);
    checkOutput("t7_addr1", addrAt(1), 32'h62);
    checkOutput("t7_ndone", 32'(doneCyc.size()), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
